// File: rtl/karatsuba_clmul_seq.sv
// Sequential carry-less multiplier built around one 2x2 Karatsuba cell.
// One digit pair per cycle, XOR-accumulated into a double-width register.

module mul_2_module (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);

  logic lo;
  logic hi;
  logic mid;

  // Karatsuba: middle term from (a0^a1)(b0^b1) minus the outer terms
  assign lo  = a_i[0] & b_i[0];
  assign hi  = a_i[1] & b_i[1];
  assign mid = ((a_i[0] ^ a_i[1]) & (b_i[0] ^ b_i[1])) ^ lo ^ hi;
  assign p_o = {1'b0, hi, mid, lo};

endmodule

module karatsuba_clmul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int D  = WIDTH / 2;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   i_q, i_d;
  logic [CW-1:0]   j_q, j_d;

  logic [1:0]      a_dig;
  logic [1:0]      b_dig;
  logic [3:0]      p4;
  logic [CW:0]     dsum;
  logic [CW+1:0]   sh;
  logic [PW-1:0]   pp;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < D; k++) begin
      if (i_q == CW'(k)) a_dig = a_q[2*k +: 2];
      if (j_q == CW'(k)) b_dig = b_q[2*k +: 2];
    end
  end

  mul_2_module u_cell (
    .a_i(a_dig),
    .b_i(b_dig),
    .p_o(p4)
  );

  // digit weights add: shift by 2*(i+j)
  assign dsum = {1'b0, i_q} + {1'b0, j_q};
  assign sh   = {dsum, 1'b0};
  assign pp   = {{(PW-4){1'b0}}, p4} << sh;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_q ^ pp;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = S_DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_p     = acc_q;

endmodule
